// File: rtl/seg_frame_capture.sv
// Recovers a 0-99 count from a multiplexed active-low two-digit 7-segment bus.
// Optional macro SEG_BLANK_ZERO_EN: an all-off tens digit decodes as 0 (leading-zero blanking).
module seg_frame_capture #(
    parameter int unsigned STABLE_CYC = 4,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic [1:0] an_in,
    output logic [6:0] cnt_out,
    output logic [3:0] tens_bcd,
    output logic [3:0] ones_bcd,
    output logic       valid,
    output logic       err
);

    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, HAVE_T, HAVE_O, EMIT} state_t;

    state_t        state;
    logic [8:0]    samp;
    logic [3:0]    stab_cnt;
    logic          acc;
    logic [1:0]    acc_an;
    logic [6:0]    acc_seg;
    logic [3:0]    t_q, o_q;
    logic [TW-1:0] tmo;

    logic          match, strobe_ok, is_tens, dig_ok;
    logic [3:0]    dig, t_sel, o_sel;
    logic [6:0]    sum;

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b0000001: decode = 5'h10;
            7'b1001111: decode = 5'h11;
            7'b0010010: decode = 5'h12;
            7'b0000110: decode = 5'h13;
            7'b1001100: decode = 5'h14;
            7'b0100100: decode = 5'h15;
            7'b0100000: decode = 5'h16;
            7'b0001111: decode = 5'h17;
            7'b0000000: decode = 5'h18;
            7'b0000100: decode = 5'h19;
            default:    decode = 5'h00;
        endcase
    endfunction

    assign match     = ({an_in, seg_in} == samp);
    assign strobe_ok = (an_in == 2'b01) || (an_in == 2'b10);

    // acc is a one-cycle pulse raised as stab_cnt steps to STABLE_CYC-1; the
    // accepted pattern is captured alongside so the FSM sees it the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp     <= {2'b11, 7'h7F};
            stab_cnt <= '0;
            acc      <= 1'b0;
            acc_an   <= 2'b11;
            acc_seg  <= '1;
        end else begin
            samp    <= {an_in, seg_in};
            acc_an  <= an_in;
            acc_seg <= seg_in;
            acc     <= match && strobe_ok && (stab_cnt == 4'(STABLE_CYC - 2));
            if (!match)
                stab_cnt <= '0;
            else if (stab_cnt != 4'(STABLE_CYC))
                stab_cnt <= stab_cnt + 4'd1;
        end
    end

    always_comb begin
        is_tens        = (acc_an == 2'b01);
        {dig_ok, dig}  = decode(acc_seg);
`ifdef SEG_BLANK_ZERO_EN
        if (is_tens && (acc_seg == 7'h7F))
            {dig_ok, dig} = 5'h10;
`endif
        t_sel = (state == HAVE_O) ? dig : t_q;
        o_sel = (state == HAVE_T) ? dig : o_q;
        sum   = {t_sel, 3'b000} + {2'b00, t_sel, 1'b0} + {3'b000, o_sel};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            t_q      <= '0;
            o_q      <= '0;
            tmo      <= '0;
            cnt_out  <= '0;
            tens_bcd <= '0;
            ones_bcd <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    tmo <= '0;
                    if (acc) begin
                        if (!dig_ok) begin
                            err <= 1'b1;
                        end else if (is_tens) begin
                            t_q   <= dig;
                            state <= HAVE_T;
                        end else begin
                            o_q   <= dig;
                            state <= HAVE_O;
                        end
                    end
                end
                HAVE_T, HAVE_O: begin
                    // Completing accept is checked before the timeout so it wins a tie.
                    if (acc && !dig_ok) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (acc && (is_tens == (state == HAVE_O))) begin
                        cnt_out  <= sum;
                        tens_bcd <= t_sel;
                        ones_bcd <= o_sel;
                        valid    <= 1'b1;
                        state    <= EMIT;
                    end else if (acc) begin
                        if (is_tens)
                            t_q <= dig;
                        else
                            o_q <= dig;
                        tmo <= '0;
                    end else if (tmo == TW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                EMIT:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seg_frame_capture.md
Name: seg_frame_capture

Overview:
- Receive-side counterpart of the two-digit 7-segment count decoder. It observes a time-multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode strobes) and recovers the displayed 0-99 value.
- Used as a loop-back checker and readback path for the century-clock display: filters strobe glitches, validates each digit pattern, assembles tens and ones, and emits the binary count with a valid pulse.

Parameters:
- STABLE_CYC, 4: consecutive identical {an_in, seg_in} samples required before a digit is accepted. Must be 2..15.
- TIMEOUT, 1000: maximum cycles allowed between the first and second accepted digit of a frame. Must be >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- seg_in  input  7  segment lines, active-low; bit6 = a ... bit0 = g.
- an_in  input  2  digit strobes, active-low. 2'b01 = tens digit selected; 2'b10 = ones digit selected; 2'b11 = blank; 2'b00 = illegal.
- cnt_out  output  7  recovered count, 0..99; held between frames.
- tens_bcd  output  4  recovered tens digit.
- ones_bcd  output  4  recovered ones digit.
- valid  output  1  one-cycle pulse: cnt_out/tens_bcd/ones_bcd updated.
- err  output  1  one-cycle pulse: invalid pattern or frame timeout.

Behaviour:
- Reset (async assert, sync release): cnt_out=0, tens_bcd=0, ones_bcd=0, valid=0, err=0, FSM=IDLE, stability and timeout counters cleared, sample register = {2'b11, 7'h7F}. Reset mid-frame discards partial digits.
- Input sampling:
  - {an_in, seg_in} registered every cycle.
  - stab_cnt increments when the sample equals the previous sample, saturating at STABLE_CYC; any change resets it to 0.
  - An accept event fires for exactly one cycle, when stab_cnt reaches STABLE_CYC-1, and only if an_in is 2'b01 or 2'b10. Blank (11) and illegal (00) strobes never accept.
  - Minimum latency from the input settling to the accept event is STABLE_CYC cycles.
- Pattern decode (active-low abcdefg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Any other pattern is invalid.
- Accepting an invalid pattern: err pulses the next cycle; FSM returns to IDLE; partial digits are discarded.
- FSM states: IDLE, HAVE_T, HAVE_O, EMIT.
  - IDLE: valid tens -> latch t, go HAVE_T. Valid ones -> latch o, go HAVE_O.
  - HAVE_T: valid ones -> latch o, go EMIT. Valid tens -> overwrite t, restart timeout.
  - HAVE_O: valid tens -> latch t, go EMIT. Valid ones -> overwrite o, restart timeout.
  - HAVE_T/HAVE_O timeout: counter counts from 0 on state entry; at TIMEOUT-1 err pulses and FSM goes IDLE. If a completing accept and the timeout occur in the same cycle, the accept wins.
  - EMIT (one cycle): cnt_out = t*10 + o, computed as (t<<3)+(t<<1)+o, 7 bits, max 99. tens_bcd=t, ones_bcd=o, valid=1. Next state IDLE.
- Outputs are registered; valid rises one cycle after the completing accept event.
- valid and err are never asserted in the same cycle.

Optional Feature:
- SEG_BLANK_ZERO_EN defined: tens strobe with seg_in=1111111 (leading-zero suppression) decodes as tens=0, valid. Ones blank remains invalid.
- SEG_BLANK_ZERO_EN undefined: 1111111 is invalid on either digit and produces err.

Test Plan:
1. Tens then ones: an_in=01, seg_in=0010010 for 4 cycles, then an_in=10, seg_in=0100100 for 4 cycles -> single valid pulse; cnt_out=25, tens_bcd=2, ones_bcd=5; err stays 0.
2. Ones first and boundaries: ones 0000100 then tens 0000100 -> cnt_out=99; then frame 0000001/0000001 -> cnt_out=0, valid pulses, tens_bcd=0.
3. Glitch filter: tens 1001111 held 3 cycles, then blank -> no accept; FSM stays IDLE; no valid, no err.
4. Invalid pattern: an_in=01, seg_in=1111110 for 4 cycles -> err pulses once; no valid; cnt_out keeps its previous value.
5. Timeout: accept tens 3 (0000110), then hold blank for 1000 cycles -> err pulses at timeout; a following ones 7 alone does not emit valid.
6. Reset mid-frame: accept tens 4, assert rst_n=0 for 2 cycles, then deliver ones 1 -> no valid. A full frame 4/1 afterwards -> cnt_out=41. With SEG_BLANK_ZERO_EN, blank tens + ones 8 -> cnt_out=8.
